// File: rtl/sfx_tone_sequencer.sv
// Multi-step square-wave sound-effect player: a rising trigger plays one of NUM_SFX
// effects, each a STEPS-long list of (half-period, duration) pairs taken from parameter tables.
module sfx_tone_sequencer #(
  parameter int NUM_SFX = 2,
  parameter int STEPS   = 4,
  parameter int HALF_W  = 17,
  parameter int DUR_W   = 24,
  parameter logic [NUM_SFX*STEPS*HALF_W-1:0] HALF_TAB = '0,
  parameter logic [NUM_SFX*STEPS*DUR_W-1:0]  DUR_TAB  = '0,
  parameter int SEL_W   = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             trigger,
  input  logic [SEL_W-1:0] sfx_sel,
  input  logic             mute,
  output logic             sound_out,
  output logic             busy,
  output logic             done
);

  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic {IDLE, PLAY} state_t;

  function automatic logic [HALF_W-1:0] halfOf(input int s, input int k);
    return HALF_TAB[(s*STEPS+k)*HALF_W +: HALF_W];
  endfunction

  function automatic logic [DUR_W-1:0] durOf(input int s, input int k);
    return DUR_TAB[(s*STEPS+k)*DUR_W +: DUR_W];
  endfunction

  state_t              state, stateN;
  logic                trigQ;
  logic [SEL_W-1:0]    sel, selN, ldSel;
  logic [STEP_W-1:0]   step, stepN, ldStep;
  logic [HALF_W-1:0]   halfCnt, halfCntN, curHalf, newHalf;
  logic [DUR_W-1:0]    durCnt, durCntN, newDur;
  logic                phase, phaseN, soundN, doneN;
  logic                start, validStart, ld;

  assign start      = trigger & ~trigQ;
  assign validStart = start && ({1'b0, sfx_sel} < (SEL_W+1)'(NUM_SFX));
  assign busy       = (state == PLAY);

  always_comb begin
    stateN   = state;
    selN     = sel;
    stepN    = step;
    halfCntN = halfCnt;
    durCntN  = durCnt;
    phaseN   = phase;
    doneN    = 1'b0;
    ld       = 1'b0;
    ldSel    = sel;
    ldStep   = step;
    newHalf  = '0;
    newDur   = '0;
    curHalf  = halfOf(int'(sel), int'(step));

    if (validStart) begin
      // start wins over a simultaneous natural finish, so no done pulse here
      stateN = PLAY;
      ld     = 1'b1;
      ldSel  = sfx_sel;
      ldStep = '0;
    end else if (state == PLAY) begin
      if (durCnt == '0) begin
        if (step == STEP_W'(STEPS-1)) begin
          stateN = IDLE;
          phaseN = 1'b0;
          doneN  = 1'b1;
        end else begin
          ld     = 1'b1;
          ldStep = step + 1'b1;
        end
      end else begin
        durCntN = durCnt - 1'b1;
        if (curHalf == '0) begin
          phaseN = 1'b0;
        end else if (halfCnt == '0) begin
          halfCntN = curHalf - 1'b1;
          phaseN   = ~phase;
        end else begin
          halfCntN = halfCnt - 1'b1;
        end
      end
    end

    // step load: tone restarts in phase; a zero half-period is a rest
    if (ld) begin
      newHalf  = halfOf(int'(ldSel), int'(ldStep));
      newDur   = durOf(int'(ldSel), int'(ldStep));
      selN     = ldSel;
      stepN    = ldStep;
      halfCntN = (newHalf == '0) ? '0 : newHalf - 1'b1;
      durCntN  = (newDur == '0) ? '0 : newDur - 1'b1;
      phaseN   = (newHalf != '0);
    end

    soundN = (stateN == PLAY) & phaseN & ~mute;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      trigQ     <= 1'b0;
      sel       <= '0;
      step      <= '0;
      halfCnt   <= '0;
      durCnt    <= '0;
      phase     <= 1'b0;
      sound_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= stateN;
      trigQ     <= trigger;
      sel       <= selN;
      step      <= stepN;
      halfCnt   <= halfCntN;
      durCnt    <= durCntN;
      phase     <= phaseN;
      sound_out <= soundN;
      done      <= doneN;
    end
  end

endmodule

// File: tb/tb_sfx_tone_sequencer.sv
// Scoreboard bench: stimulus pushes expected {sound_out,busy,done} per cycle, monitor pops after each edge.
module tb_sfx_tone_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       trigger = 1'b0;
  logic       mute = 1'b0;
  logic [1:0] sfx_sel = 2'd0;
  logic       sound_out, busy, done;

  always #5 clk = ~clk;

  sfx_tone_sequencer #(
    .NUM_SFX (2),
    .STEPS   (3),
    .HALF_W  (17),
    .DUR_W   (24),
    .HALF_TAB({17'd1, 17'd1, 17'd1, 17'd3, 17'd0, 17'd2}),
    .DUR_TAB ({24'd2, 24'd2, 24'd2, 24'd6, 24'd4, 24'd8}),
    .SEL_W   (2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .trigger  (trigger),
    .sfx_sel  (sfx_sel),
    .mute     (mute),
    .sound_out(sound_out),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic  o;
    logic  b;
    logic  d;
    string tag;
  } exp_t;

  exp_t expQ[$];
  int   nCmp = 0;
  int   nBad = 0;

  // hand-derived waveforms, cycle 0 at the MSB
  logic [17:0] wave0 = 18'b110011_00_0000_111000;
  logic [5:0]  wave1 = 6'b101010;

  task automatic check(input string tag, input logic o, input logic b, input logic d);
    nCmp++;
    if ({sound_out, busy, done} !== {o, b, d}) begin
      nBad++;
      $display("FAIL %s: out/busy/done got %b%b%b expected %b%b%b",
               tag, sound_out, busy, done, o, b, d);
    end
  endtask

  task automatic cyc(input logic t, input logic [1:0] s, input logic m,
                     input logic o, input logic b, input logic d, input string tag);
    exp_t e;
    @(negedge clk);
    trigger = t;
    sfx_sel = s;
    mute    = m;
    e.o = o; e.b = b; e.d = d; e.tag = tag;
    expQ.push_back(e);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("%s_i%0d", tag, i));
  endtask

  task automatic playSfx0(input string tag, input int muteUpTo, input logic hold);
    for (int i = 0; i < 18; i++)
      cyc((i == 0) || hold, 2'd0, i < muteUpTo, wave0[17-i] & !(i < muteUpTo), 1'b1, 1'b0,
          $sformatf("%s_c%0d", tag, i));
    cyc(hold, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, $sformatf("%s_done", tag));
  endtask

  task automatic playSfx1(input string tag);
    for (int i = 0; i < 6; i++)
      cyc(i == 0, 2'd1, 1'b0, wave1[5-i], 1'b1, 1'b0, $sformatf("%s_c%0d", tag, i));
    cyc(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, $sformatf("%s_done", tag));
  endtask

  // monitor
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      check(e.tag, e.o, e.b, e.d);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 check("reset", 1'b0, 1'b0, 1'b0);
    #10;
    @(negedge clk) reset_n = 1'b1;
    idle(2, "idle0");

    playSfx0("t1", 0, 1'b0);
    idle(2, "t1");

    // trigger held 40 cycles: one effect only
    playSfx0("t2", 0, 1'b1);
    for (int i = 0; i < 21; i++) cyc(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("t2_hold%0d", i));
    idle(2, "t2");

    // sfx1 interrupted at cycle 3 by sfx0
    cyc(1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, "t3_s1c0");
    cyc(1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, "t3_s1c1");
    cyc(1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, "t3_s1c2");
    playSfx0("t3", 0, 1'b0);
    idle(2, "t3");

    cyc(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, "t4_sel2");
    idle(4, "t4");

    playSfx0("t5", 8, 1'b0);
    idle(2, "t5");

    // async reset in the middle of step1
    for (int i = 0; i < 10; i++)
      cyc(i == 0, 2'd0, 1'b0, wave0[17-i], 1'b1, 1'b0, $sformatf("t6_c%0d", i));
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1 check("t6_async", 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, "t6_rst0");
    cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, "t6_rst1");
    @(negedge clk) reset_n = 1'b1;
    expQ.push_back('{1'b0, 1'b0, 1'b0, "t6_rel"});
    idle(4, "t6_post");
    playSfx1("t6_s1");
    idle(2, "end");

    repeat (3) @(negedge clk);
    nCmp++;
    if (expQ.size() != 0) begin
      nBad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
